// File: rtl/spi_flash_cmd_seq.sv
// SPI-flash command sequencer: optional WREN, opcode plus optional address,
// optional RDSR polling until a status bit clears. Mode 0, MSB first.
module spi_flash_cmd_seq #(
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 24,
    parameter int POLL_BIT = 0,
    parameter int POLL_MAX = 1024,
    parameter int CS_GAP   = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [7:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic              use_addr,
    input  logic              use_wren,
    input  logic              poll_en,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [7:0]        status_reg,
    output logic [15:0]       poll_count,
    output logic              CS,
    output logic              CLOCK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int BC_W   = $clog2(ADDR_W + 1);
    localparam int TM_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, WREN, GAP1, CMD, ADDR, GAP2,
        POLL_CMD, POLL_RD, GAP3, FIN
    } state_t;

    state_t state_q, state_d;

    logic [TM_W-1:0]   tmr_q, tmr_d;
    logic [BC_W-1:0]   bit_q;
    logic [ADDR_W-1:0] tx_q;
    logic [7:0]        rx_q;
    logic [7:0]        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic              use_addr_q;
    logic              poll_q;
    logic              to_q;

    logic              in_shift, in_gap, tick, gap_end;
    logic              rise, fall, last, rd_stop, load;
    logic [15:0]       cnt_inc;
    logic [7:0]        op_src;
    logic [ADDR_W-1:0] load_val;
    logic [BC_W-1:0]   load_len;

    function automatic logic is_shift(input state_t s);
        return (s == WREN) || (s == CMD) || (s == ADDR) ||
               (s == POLL_CMD) || (s == POLL_RD);
    endfunction

    always_comb begin
        in_shift = is_shift(state_q);
        in_gap   = (state_q == GAP1) || (state_q == GAP2) ||
                   (state_q == GAP3);
        tick     = (tmr_q == TM_W'(CLK_DIV - 1));
        gap_end  = in_gap && (tmr_q == TM_W'(CS_GAP - 1));
        rise     = in_shift && tick && !CLOCK;
        fall     = in_shift && tick && CLOCK;
        last     = fall && (bit_q == BC_W'(1));
        cnt_inc  = (poll_count == 16'hFFFF) ? poll_count
                                            : poll_count + 16'd1;
        rd_stop  = !rx_q[POLL_BIT] || (cnt_inc == 16'(POLL_MAX));
        busy     = (state_q != IDLE);
        done     = (state_q == FIN) && !to_q;
        timeout  = (state_q == FIN) && to_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start)   state_d = use_wren ? WREN : CMD;
            WREN:     if (last)    state_d = GAP1;
            GAP1:     if (gap_end) state_d = CMD;
            CMD:      if (last)    state_d = use_addr_q ? ADDR : GAP2;
            ADDR:     if (last)    state_d = GAP2;
            GAP2:     if (gap_end) state_d = poll_q ? POLL_CMD : FIN;
            POLL_CMD: if (last)    state_d = POLL_RD;
            POLL_RD:  if (last && rd_stop) state_d = GAP3;
            GAP3:     if (gap_end) state_d = FIN;
            FIN:                   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Segment reload: entering a shift state, or the next status byte.
    always_comb begin
        op_src   = (state_q == IDLE) ? opcode : opcode_q;
        load     = is_shift(state_d) && ((state_d != state_q) || last);
        load_val = '0;
        load_len = BC_W'(8);
        unique case (state_d)
            WREN:     load_val = ADDR_W'(8'h06) << (ADDR_W - 8);
            CMD:      load_val = ADDR_W'(op_src) << (ADDR_W - 8);
            ADDR: begin
                load_val = addr_q;
                load_len = BC_W'(ADDR_W);
            end
            POLL_CMD: load_val = ADDR_W'(8'h05) << (ADDR_W - 8);
            default:  load_val = '0;
        endcase
    end

    always_comb begin
        if (state_d != state_q) tmr_d = '0;
        else if (in_shift)      tmr_d = tick ? '0 : tmr_q + TM_W'(1);
        else if (in_gap)        tmr_d = tmr_q + TM_W'(1);
        else                    tmr_d = '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            CS         <= 1'b1;
            CLOCK      <= 1'b0;
            MOSI       <= 1'b0;
            status_reg <= '0;
            poll_count <= '0;
            tmr_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            opcode_q   <= '0;
            addr_q     <= '0;
            use_addr_q <= 1'b0;
            poll_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            CS    <= !is_shift(state_d);

            if (!is_shift(state_d) || (state_d != state_q))
                CLOCK <= 1'b0;
            else if (tick)
                CLOCK <= !CLOCK;

            if (load) begin
                tx_q  <= load_val;
                bit_q <= load_len;
            end else if (fall) begin
                tx_q  <= tx_q << 1;
                bit_q <= bit_q - BC_W'(1);
            end

            if (!is_shift(state_d)) MOSI <= 1'b0;
            else if (load)          MOSI <= load_val[ADDR_W-1];
            else if (fall)          MOSI <= tx_q[ADDR_W-2];

            if (rise && (state_q == POLL_RD))
                rx_q <= {rx_q[6:0], MISO};

            if (last && (state_q == POLL_RD)) begin
                status_reg <= rx_q;
                poll_count <= cnt_inc;
                if (rx_q[POLL_BIT] && (cnt_inc == 16'(POLL_MAX)))
                    to_q <= 1'b1;
            end

            if ((state_q == IDLE) && start) begin
                opcode_q   <= opcode;
                addr_q     <= addr;
                use_addr_q <= use_addr;
                poll_q     <= poll_en;
                poll_count <= '0;
                to_q       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Bench for spi_flash_cmd_seq: pin-level SPI monitor with a status-byte
// flash model; expected transactions are derived from the command flags.
module tb_spi_flash_cmd_seq;

    localparam int CLK_DIV  = 2;
    localparam int ADDR_W   = 24;
    localparam int POLL_BIT = 0;
    localparam int POLL_MAX = 8;
    localparam int CS_GAP   = 4;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        opcode = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic              use_addr = 1'b0;
    logic              use_wren = 1'b0;
    logic              poll_en = 1'b0;
    logic              busy, done, timeout;
    logic [7:0]        status_reg;
    logic [15:0]       poll_count;
    logic              CS, CLOCK, MOSI;
    logic              MISO = 1'b0;

    always #5 ACLK = ~ACLK;

    spi_flash_cmd_seq #(
        .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .POLL_BIT(POLL_BIT),
        .POLL_MAX(POLL_MAX), .CS_GAP(CS_GAP)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .opcode(opcode),
        .addr(addr), .use_addr(use_addr), .use_wren(use_wren),
        .poll_en(poll_en), .busy(busy), .done(done), .timeout(timeout),
        .status_reg(status_reg), .poll_count(poll_count),
        .CS(CS), .CLOCK(CLOCK), .MOSI(MOSI), .MISO(MISO)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Monitor / flash model state
    int          win_bits[$];
    int          win_lead[$];
    int          gap_len[$];
    logic [7:0]  mosi_b[$];
    int          cur_bits = 0, cur_lead = 0, cur_gap = 0;
    logic [7:0]  cur_byte = '0, first_byte = '0, sb;
    logic        had_win = 1'b0;
    logic        p_cs = 1'b1, p_sck = 1'b0, p_done = 1'b0, p_to = 1'b0;
    int          viol = 0, done_cnt = 0, to_cnt = 0;
    int          wip_n = 0;
    logic [7:0]  bval = '0, cval = '0;
    logic [7:0]  exp_status = '0;

    function automatic logic [7:0] sbyte(input int j);
        return (j < wip_n) ? bval : cval;
    endfunction

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (CS && CLOCK) viol++;
            if ((done || timeout) && !busy) viol++;
            if (done && timeout) viol++;
            if ((done && p_done) || (timeout && p_to)) viol++;
            if ((p_done || p_to) && busy) viol++;
            if (done) done_cnt++;
            if (timeout) to_cnt++;
        end
        if (p_cs && !CS) begin
            if (had_win) gap_len.push_back(cur_gap);
            cur_bits = 0;
            cur_lead = 0;
            first_byte = '0;
        end
        if (!p_cs && CS) begin
            win_bits.push_back(cur_bits);
            win_lead.push_back(cur_lead);
            had_win = 1'b1;
            cur_gap = 0;
        end
        if (CS) begin
            cur_gap++;
        end else begin
            if (CLOCK && !p_sck) begin
                cur_byte = {cur_byte[6:0], MOSI};
                cur_bits++;
                if (cur_bits % 8 == 0) begin
                    mosi_b.push_back(cur_byte);
                    if (cur_bits == 8) first_byte = cur_byte;
                end
            end
            if (!CLOCK && cur_bits == 0) cur_lead++;
            if (!CLOCK) begin
                if (first_byte == 8'h05 && cur_bits >= 8) begin
                    sb = sbyte((cur_bits - 8) / 8);
                    MISO = sb[7 - ((cur_bits - 8) % 8)];
                end else begin
                    MISO = 1'b0;
                end
            end
        end
        p_cs = CS;
        p_sck = CLOCK;
        p_done = done;
        p_to = timeout;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic clr();
        win_bits.delete();
        win_lead.delete();
        gap_len.delete();
        mosi_b.delete();
        had_win = 1'b0;
        done_cnt = 0;
        to_cnt = 0;
        viol = 0;
    endtask

    task automatic run_seq(input logic [7:0] op, input logic [23:0] a,
                           input logic ua, input logic uw, input logic pe,
                           input int wn, input logic [7:0] bv,
                           input logic [7:0] cv, input logic poke);
        int         n, guard;
        logic       tmo;
        int         ew[$];
        logic [7:0] eb[$];
        clr();
        wip_n = wn;
        bval = bv;
        cval = cv;
        opcode = op;
        addr = a;
        use_addr = ua;
        use_wren = uw;
        poll_en = pe;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_acc", busy, 1);
        chk("pc_clr", poll_count, 0);
        if (poke) begin
            tick(3);
            opcode = ~op;
            addr = ~a;
            use_addr = ~ua;
            poll_en = ~pe;
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
        guard = 0;
        while (busy && guard < 5000) begin
            tick(1);
            guard++;
        end
        chk("end_seq", guard < 5000, 1);
        tick(12);

        n = pe ? ((wn < POLL_MAX) ? wn + 1 : POLL_MAX) : 0;
        tmo = pe && (wn >= POLL_MAX);
        if (uw) begin
            ew.push_back(8);
            eb.push_back(8'h06);
        end
        ew.push_back(ua ? 8 + ADDR_W : 8);
        eb.push_back(op);
        if (ua)
            for (int i = ADDR_W / 8 - 1; i >= 0; i--)
                eb.push_back(a[i*8 +: 8]);
        if (pe) begin
            ew.push_back(8 + 8 * n);
            eb.push_back(8'h05);
            repeat (n) eb.push_back(8'h00);
            exp_status = tmo ? bv : cv;
        end

        chk("n_win", win_bits.size(), ew.size());
        for (int i = 0; i < ew.size(); i++) begin
            chk("win_bits", (i < win_bits.size()) ? win_bits[i] : -1, ew[i]);
            chk("cs_lead", (i < win_lead.size()) ? win_lead[i] : -1, CLK_DIV);
        end
        chk("n_gap", gap_len.size(), ew.size() - 1);
        for (int i = 0; i < gap_len.size(); i++)
            chk("cs_gap", gap_len[i], CS_GAP);
        chk("n_byte", mosi_b.size(), eb.size());
        for (int i = 0; i < eb.size(); i++)
            chk("mosi", (i < mosi_b.size()) ? mosi_b[i] : 'h1FF, eb[i]);
        chk("done_cnt", done_cnt, tmo ? 0 : 1);
        chk("to_cnt", to_cnt, tmo ? 1 : 0);
        chk("poll_count", poll_count, n);
        chk("status_reg", status_reg, exp_status);
        chk("proto", viol, 0);
        chk("cs_idle", CS, 1);
    endtask

    initial begin
        int guard;
        tick(3);
        ARESET = 1'b0;
        clr();
        tick(100);
        chk("rst_cs", CS, 1);
        chk("rst_clk", CLOCK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_status", status_reg, 0);
        chk("rst_pc", poll_count, 0);
        chk("rst_pulses", done_cnt + to_cnt, 0);
        chk("rst_nowin", win_bits.size(), 0);

        run_seq(8'hC7, 24'h0, 1'b0, 1'b1, 1'b0, 0, 8'h03, 8'h00, 1'b0);
        run_seq(8'h20, 24'h012345, 1'b1, 1'b0, 1'b1, 3, 8'h03, 8'h00, 1'b0);
        run_seq(8'h20, 24'h0, 1'b0, 1'b0, 1'b1, 1000, 8'h01, 8'h00, 1'b0);
        run_seq(8'h02, 24'hABCDEF, 1'b1, 1'b1, 1'b1, 7, 8'h81, 8'h7E, 1'b1);

        // Abort during the address phase
        clr();
        opcode = 8'h02;
        addr = 24'h5A5A5A;
        use_addr = 1'b1;
        use_wren = 1'b0;
        poll_en = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        guard = 0;
        while (cur_bits < 16 && guard < 2000) begin
            tick(1);
            guard++;
        end
        chk("reach_addr", guard < 2000, 1);
        ARESET = 1'b1;
        tick(1);
        chk("abort_cs", CS, 1);
        chk("abort_clk", CLOCK, 0);
        chk("abort_busy", busy, 0);
        chk("abort_status", status_reg, 0);
        ARESET = 1'b0;
        exp_status = '0;
        tick(10);
        chk("abort_nopulse", done_cnt + to_cnt, 0);
        chk("abort_idle", busy, 0);

        run_seq(8'h03, 24'h000100, 1'b1, 1'b0, 1'b1, 0, 8'h01, 8'h00, 1'b0);

        for (int k = 0; k < 20; k++) begin
            logic [7:0] bv, cv;
            bv = 8'($urandom) | 8'h01;
            cv = 8'($urandom) & 8'hFE;
            run_seq(8'($urandom), 24'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 10),
                    bv, cv, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
